// File: rtl/mem_responder.sv
// Word-addressed memory responder with a valid/ready request port and programmable wait states.
// Optional MEM_ERR_EN adds the rsp_err port and flags misaligned or out-of-range accesses.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy
`ifdef MEM_ERR_EN
  ,
  output logic        rsp_err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          commit;
  logic          com_we;
  logic [31:0]   com_addr;
  logic [31:0]   com_wdata;
  logic [AW-1:0] com_idx;
  logic          com_err;

  assign req_ready = (state == IDLE);
  assign busy      = !req_ready;
  assign accept    = req_valid && req_ready;

  // With zero wait states the commit happens on the accept edge, so live inputs are used.
  assign commit    = (accept && ZERO_WAIT) || (state == WAIT && cnt == 4'd0);
  assign com_we    = (state == IDLE) ? req_we    : lat_we;
  assign com_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign com_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign com_idx   = com_addr[AW+1:2];

`ifdef MEM_ERR_EN
  assign com_err = (com_addr[1:0] != 2'b00) || (|com_addr[31:AW+2]);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{com_addr[31:AW+2], com_addr[1:0]};
  assign com_err = 1'b0;
`endif

  // The array is never reset; gating on reset keeps an interrupted write from landing.
  always_ff @(posedge clk) begin
    if (reset && commit && com_we && !com_err)
      mem[com_idx] <= com_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
`ifdef MEM_ERR_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (ZERO_WAIT) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= 4'(cnt - 4'd1);
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
`ifdef MEM_ERR_EN
          rsp_err   <= 1'b0;
`endif
        end
      endcase

      // Read data is loaded only on a committed read; writes leave the last read value in place.
      if (commit) begin
        if (com_err)
          rsp_rdata <= 32'd0;
        else if (!com_we)
          rsp_rdata <= mem[com_idx];
`ifdef MEM_ERR_EN
        rsp_err <= com_err;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
// Checks reset, wait-state timing, back-to-back spacing, wrap or error handling, and mid-access reset.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, busy;
  logic [31:0] rsp_rdata;
  logic        v0, we0;
  logic [31:0] a0, d0;
  logic        ready0, rvalid0, busy0;
  logic [31:0] rdata0;
`ifdef MEM_ERR_EN
  logic        rsp_err, err0;
`endif

  int total  = 0;
  int passed = 0;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
`ifdef MEM_ERR_EN
    , .rsp_err(rsp_err)
`endif
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_we(we0),
    .req_addr(a0), .req_wdata(d0), .req_ready(ready0),
    .rsp_valid(rvalid0), .rsp_rdata(rdata0), .busy(busy0)
`ifdef MEM_ERR_EN
    , .rsp_err(err0)
`endif
  );

  // One access on the WAIT_CYCLES=2 instance; inputs are scrambled after acceptance.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic got, output logic [31:0] rdata, output logic err,
                        output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0BAD_0BAD;
    got = 1'b0; rdata = 32'd0; err = 1'b0; lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        got = 1'b1; rdata = rsp_rdata; lat = i;
`ifdef MEM_ERR_EN
        err = rsp_err;
`endif
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h1;
    v0 = 1'b1; we0 = 1'b0; a0 = 32'h0; d0 = 32'h0;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passed++;
    total++; if (rsp_rdata !== 32'd0) $display("[TB] FAIL reset_rdata: got %h expected 0", rsp_rdata); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    req_valid = 1'b0; v0 = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_wait_timing();
    logic [3:0] exp_busy  = 4'b0111;
    logic [3:0] exp_valid = 4'b0100;
    logic got, err; logic [31:0] rd; int lat;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("[TB] FAIL wr_ready_before: got %b expected 1", req_ready); else passed++;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h14; req_wdata = 32'h0;
      end
      total++; if (busy !== exp_busy[k]) $display("[TB] FAIL wr_busy_%0d: got %b expected %b", k, busy, exp_busy[k]); else passed++;
      total++; if (rsp_valid !== exp_valid[k]) $display("[TB] FAIL wr_rsp_valid_%0d: got %b expected %b", k, rsp_valid, exp_valid[k]); else passed++;
    end
    access(1'b0, 32'h10, 32'h0, got, rd, err, lat);
    total++; if (got !== 1'b1) $display("[TB] FAIL rd_response: got %b expected 1", got); else passed++;
    total++; if (rd !== 32'hDEAD_BEEF) $display("[TB] FAIL rd_data: got %h expected deadbeef", rd); else passed++;
    total++; if (lat !== 2) $display("[TB] FAIL rd_latency: got %0d expected 2", lat); else passed++;
    access(1'b1, 32'h14, 32'h0, got, rd, err, lat);
    total++; if (rd !== 32'hDEAD_BEEF) $display("[TB] FAIL rdata_hold: got %h expected deadbeef", rd); else passed++;
    access(1'b0, 32'h14, 32'h0, got, rd, err, lat);
    total++; if (rd !== 32'h0) $display("[TB] FAIL rd_second_word: got %h expected 0", rd); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_valid = 4'b0101;
    logic [3:0] exp_ready = 4'b1010;
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b1; a0 = 32'h0; d0 = 32'hCAFE_0000;
    @(negedge clk);
    total++; if (rvalid0 !== 1'b1) $display("[TB] FAIL zw_write_rsp: got %b expected 1", rvalid0); else passed++;
    v0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    v0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (rvalid0 !== exp_valid[k]) $display("[TB] FAIL zw_rsp_valid_%0d: got %b expected %b", k, rvalid0, exp_valid[k]); else passed++;
      total++; if (ready0 !== exp_ready[k]) $display("[TB] FAIL zw_ready_%0d: got %b expected %b", k, ready0, exp_ready[k]); else passed++;
      if (k == 0) begin
        total++; if (rdata0 !== 32'hCAFE_0000) $display("[TB] FAIL zw_rdata: got %h expected cafe0000", rdata0); else passed++;
      end
    end
    v0 = 1'b0;
  endtask

`ifndef MEM_ERR_EN
  task automatic test_wrap();
    logic got, err; logic [31:0] rd; int lat;
    access(1'b1, 32'h400, 32'h1234, got, rd, err, lat);
    total++; if (got !== 1'b1) $display("[TB] FAIL wrap_write_rsp: got %b expected 1", got); else passed++;
    access(1'b0, 32'h000, 32'h0, got, rd, err, lat);
    total++; if (rd !== 32'h1234) $display("[TB] FAIL wrap_read_0: got %h expected 1234", rd); else passed++;
    access(1'b0, 32'h003, 32'h0, got, rd, err, lat);
    total++; if (rd !== 32'h1234) $display("[TB] FAIL wrap_read_3: got %h expected 1234", rd); else passed++;
  endtask
`else
  task automatic test_err();
    logic got, err; logic [31:0] rd; int lat;
    access(1'b1, 32'h000, 32'h77, got, rd, err, lat);
    total++; if (err !== 1'b0) $display("[TB] FAIL err_good_write: got %b expected 0", err); else passed++;
    access(1'b1, 32'h402, 32'h55, got, rd, err, lat);
    total++; if (err !== 1'b1) $display("[TB] FAIL err_range_flag: got %b expected 1", err); else passed++;
    total++; if (rd !== 32'h0) $display("[TB] FAIL err_range_rdata: got %h expected 0", rd); else passed++;
    total++; if (lat !== 2) $display("[TB] FAIL err_latency: got %0d expected 2", lat); else passed++;
    access(1'b0, 32'h002, 32'h0, got, rd, err, lat);
    total++; if (err !== 1'b1) $display("[TB] FAIL err_align_flag: got %b expected 1", err); else passed++;
    access(1'b0, 32'h000, 32'h0, got, rd, err, lat);
    total++; if (rd !== 32'h77) $display("[TB] FAIL err_mem_unchanged: got %h expected 77", rd); else passed++;
    total++; if (err !== 1'b0) $display("[TB] FAIL err_clean_read: got %b expected 0", err); else passed++;
    @(negedge clk);
    total++; if (rsp_err !== 1'b0) $display("[TB] FAIL err_idle_low: got %b expected 0", rsp_err); else passed++;
  endtask
`endif

  task automatic test_reset_mid_access();
    logic got, err; logic [31:0] rd; int lat;
    access(1'b1, 32'h8, 32'h1111, got, rd, err, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hAAAA;
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); else passed++;
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy_reset: got %b expected 0", busy); else passed++;
    total++; if (rsp_rdata !== 32'h0) $display("[TB] FAIL mid_rdata_reset: got %h expected 0", rsp_rdata); else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0) $display("[TB] FAIL mid_rsp_valid_%0d: got %b expected 0", k, rsp_valid); else passed++;
    end
    reset = 1'b1;
    access(1'b0, 32'h8, 32'h0, got, rd, err, lat);
    total++; if (rd !== 32'h1111) $display("[TB] FAIL mid_prior_contents: got %h expected 1111", rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_wait_timing();
    test_back_to_back();
`ifndef MEM_ERR_EN
    test_wrap();
`else
    test_err();
`endif
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
